fib_stream_gen: RTL and testbench
=================================

Name: fib_stream_gen

Overview:
Parametrised hardware Fibonacci engine. It is the successor to the software-driven Fibonacci program running on the single-cycle RV32 core. On a start command it generates N terms from programmable seeds and hands each term out on a valid/ready stream. In the same cycle as each handshake it writes the term into the data-memory write port at base_addr+index. It adds configurable width, term count, overflow detection with a stop/wrap mode, backpressure, and memory-address wrap.

Parameters:
DATA_W, 32, width of terms and memory data.
ADDR_W, 9, data-memory word-address width (512 words).
CNT_W, 16, width of the term counter and n_terms.
STOP_ON_OVF, 1, selects overflow handling. 1 = stop before emitting an overflowed term. 0 = wrap modulo 2^DATA_W and continue.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
start  in  1  command pulse; sampled only in IDLE.
n_terms  in  CNT_W  number of terms to produce; latched at start.
seed0  in  DATA_W  term 0; latched at start.
seed1  in  DATA_W  term 1; latched at start.
base_addr  in  ADDR_W  memory word address of term 0; latched at start.
out_valid  out  1  current term is presented.
out_ready  in  1  consumer accepts the term.
out_data  out  DATA_W  current term value.
out_index  out  CNT_W  index of the current term.
mem_we  out  1  data-memory write strobe.
mem_addr  out  ADDR_W  data-memory word address.
mem_wdata  out  DATA_W  data-memory write data.
busy  out  1  high in EMIT state.
done  out  1  one-cycle completion pulse.
overflow  out  1  sticky flag; cleared by the next accepted start.
term_count  out  CNT_W  number of terms handed off in the current or last run.

Behaviour:
- Reset (asynchronous, active-high) forces state IDLE and drives every output to 0. Latched seeds, addresses and counters clear to 0. Assertion mid-run aborts immediately; no further mem_we occurs.
- States are IDLE, EMIT and DONE. All outputs are registered except mem_we, mem_addr and mem_wdata.
- IDLE:
  - start=1 latches the inputs, clears overflow and term_count, and sets registers a=seed0, b=seed1, idx=0.
  - If n_terms=0 the next state is DONE; otherwise it is EMIT.
- EMIT:
  - out_valid=1, busy=1, out_data=a, out_index=idx.
  - out_data and out_index stay stable while out_ready=0.
- Handshake (out_valid & out_ready):
  - In the same cycle, combinationally: mem_we=1, mem_addr=(base+idx) mod 2^ADDR_W, mem_wdata=a.
  - On the clock edge: a<=b, b<=(a+b) truncated to DATA_W, idx<=idx+1, term_count<=term_count+1.
- Overflow check: at each handshake, compute ovf_next = carry-out of b+a, i.e. the term two positions ahead overflows.
  - Simpler rule that is checked instead: the term at index idx+1, once the pipeline has shifted, is tagged ovf when it was produced by a carry. Each b register carries a 1-bit ovf tag, and the a register inherits it on the shift.
  - When a handshake would present a term whose tag is set: overflow<=1.
  - If STOP_ON_OVF=1, the next state is DONE and the tagged term is never emitted or written.
  - If STOP_ON_OVF=0, the wrapped value is emitted normally.
  - Seeds never carry a tag.
- Run termination: the handshake at idx=n_terms-1 sends the next state to DONE.
- DONE: done=1 for exactly one cycle, out_valid=0, then the next state is IDLE. The first cycle in which a new start can be accepted is the cycle after done.
- start while in EMIT or DONE is ignored.
- Latency: start is sampled at edge t. From t+1 busy=1 and out_valid=1 with term 0. With out_ready held at 1, one term is handed off per cycle. done is asserted in the cycle after the final handshake.
- Outside EMIT: mem_we=0, mem_addr=0, mem_wdata=0.

Test Plan:
- Basic run: seeds 0/1, n=10, base=4, out_ready=1. Stream is 0,1,1,2,3,5,8,13,21,34 with out_index 0..9. Writes go to addresses 4..13. done pulses once, exactly 1 cycle after the 10th handshake. term_count=10. overflow=0.
- Backpressure: same run with out_ready toggling 1,0,0,1 (random). Each term is held stable while out_ready=0. Exactly 10 mem_we pulses occur, each coincident with a handshake. Sequence is unchanged.
- Stop on overflow: DATA_W=8, STOP_ON_OVF=1, seeds 0/1, n=20. Emits 14 terms ending in 233 (index 13). 377 is never emitted. overflow=1, term_count=14, done pulses.
- Wrap mode: DATA_W=8, STOP_ON_OVF=0, seeds 0/1, n=16. Index 14 is 121 (377 mod 256). Index 15 is 98 ((233+121) mod 256). overflow=1, term_count=16.
- Edge cases:
  - n=0: done pulses 1 cycle after start, with no out_valid and no mem_we.
  - ADDR_W=4, base=14, n=4: writes go to addresses 14,15,0,1.
  - start pulsed during EMIT is ignored.
- Reset mid-run: assert rst asynchronously after 3 handshakes. All outputs go to 0 immediately, with no further writes. A subsequent run with seeds 2/3, n=3 yields 2,3,5.

Source files
------------

// File: rtl/fib_stream_gen.sv
// rtl/fib_stream_gen.sv - Fibonacci term generator with valid/ready stream and memory write port
//
// Generates n_terms Fibonacci terms from two programmable seeds. Each term is
// presented on a valid/ready stream and written to data memory at base+index
// in the same cycle as its handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    run command, honoured only in IDLE
//   n_terms, seed0, seed1,   run configuration, latched on an accepted start
//   base_addr
//   out_valid/out_ready      term stream handshake
//   out_data, out_index      presented term and its index
//   mem_we/mem_addr/mem_wdata data-memory write port, combinational on handshake
//   busy                     high while emitting
//   done                     one-cycle pulse when a run ends
//   overflow                 sticky, set when an overflowed term is reached
//   term_count               terms handed off in the current or last run
module fib_stream_gen #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_OVF = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_terms,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_index,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  term_count
);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                b_tag_q, b_tag_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                overflow_q, overflow_d;
    logic [CNT_W-1:0]    term_count_q, term_count_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                hs;
    logic                last_term;
    logic [DATA_W:0]     sum_w;
    logic [ADDR_W-1:0]   idx_lo;

    assign hs        = out_valid_q & out_ready;
    assign last_term = (idx_q == (n_q - CNT_W'(1)));
    // Top bit is the carry that tags the freshly produced term as overflowed.
    assign sum_w     = {1'b0, a_q} + {1'b0, b_q};

    // Address arithmetic wraps naturally at ADDR_W bits.
    generate
        if (CNT_W >= ADDR_W) begin : g_idx_trunc
            assign idx_lo = idx_q[ADDR_W-1:0];
        end else begin : g_idx_ext
            assign idx_lo = ADDR_W'(idx_q);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            b_tag_q      <= 1'b0;
            idx_q        <= '0;
            n_q          <= '0;
            base_q       <= '0;
            overflow_q   <= 1'b0;
            term_count_q <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            b_tag_q      <= b_tag_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            base_q       <= base_d;
            overflow_q   <= overflow_d;
            term_count_q <= term_count_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = (n_terms == '0) ? S_DONE : S_EMIT;
            // A tagged b becomes the next presented term; in stop mode it is never shown.
            S_EMIT: if (hs && (last_term || (STOP_ON_OVF && b_tag_q))) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        b_tag_d      = b_tag_q;
        idx_d        = idx_q;
        n_d          = n_q;
        base_d       = base_q;
        overflow_d   = overflow_q;
        term_count_d = term_count_q;
        if (state_q == S_IDLE && start) begin
            a_d          = seed0;
            b_d          = seed1;
            b_tag_d      = 1'b0;
            idx_d        = '0;
            n_d          = n_terms;
            base_d       = base_addr;
            overflow_d   = 1'b0;
            term_count_d = '0;
        end else if (hs) begin
            a_d          = b_q;
            b_d          = sum_w[DATA_W-1:0];
            b_tag_d      = sum_w[DATA_W];
            idx_d        = idx_q + CNT_W'(1);
            term_count_d = term_count_q + CNT_W'(1);
            // Only flag terms that would actually be reached within this run.
            if (b_tag_q && !last_term) overflow_d = 1'b1;
        end
        out_valid_d = (state_d == S_EMIT);
        busy_d      = (state_d == S_EMIT);
        done_d      = (state_d == S_DONE);
    end

    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign out_data   = a_q;
    assign out_index  = idx_q;
    assign overflow   = overflow_q;
    assign term_count = term_count_q;

    assign mem_we    = hs;
    assign mem_addr  = hs ? (base_q + idx_lo) : '0;
    assign mem_wdata = hs ? a_q : '0;

endmodule

// File: tb/tb_fib_stream_gen.sv
// tb/tb_fib_stream_gen.sv - directed self-checking bench for fib_stream_gen
module tb_fib_stream_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 32-bit data, 9-bit address instance
    logic        a_start, a_ready;
    logic [15:0] a_n;
    logic [31:0] a_s0, a_s1;
    logic [8:0]  a_base;
    logic        a_valid, a_we, a_busy, a_done, a_ovf;
    logic [31:0] a_data, a_wdata;
    logic [15:0] a_index, a_tc;
    logic [8:0]  a_addr;

    // 8-bit instances (stop / wrap) sharing start, seeds and ready
    logic        q_start, q_ready;
    logic [7:0]  q_s0, q_s1;
    logic [8:0]  q_base;
    logic [15:0] s_n, w_n;
    logic        s_valid, s_we, s_busy, s_done, s_ovf;
    logic [7:0]  s_data, s_wdata;
    logic [15:0] s_index, s_tc;
    logic [8:0]  s_addr;
    logic        w_valid, w_we, w_busy, w_done, w_ovf;
    logic [7:0]  w_data, w_wdata;
    logic [15:0] w_index, w_tc;
    logic [8:0]  w_addr;

    // 4-bit address instance
    logic [15:0] r_n;
    logic [31:0] r_s0, r_s1;
    logic [3:0]  r_base;
    logic        r_valid, r_we, r_busy, r_done, r_ovf;
    logic [31:0] r_data, r_wdata;
    logic [15:0] r_index, r_tc;
    logic [3:0]  r_addr;

    fib_stream_gen dut_a (
        .clk(clk), .rst(rst), .start(a_start), .n_terms(a_n), .seed0(a_s0), .seed1(a_s1),
        .base_addr(a_base), .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
        .out_index(a_index), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .busy(a_busy), .done(a_done), .overflow(a_ovf), .term_count(a_tc));

    fib_stream_gen #(.DATA_W(8), .STOP_ON_OVF(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(q_start), .n_terms(s_n), .seed0(q_s0), .seed1(q_s1),
        .base_addr(q_base), .out_valid(s_valid), .out_ready(q_ready), .out_data(s_data),
        .out_index(s_index), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .busy(s_busy), .done(s_done), .overflow(s_ovf), .term_count(s_tc));

    fib_stream_gen #(.DATA_W(8), .STOP_ON_OVF(1'b0)) dut_w (
        .clk(clk), .rst(rst), .start(q_start), .n_terms(w_n), .seed0(q_s0), .seed1(q_s1),
        .base_addr(q_base), .out_valid(w_valid), .out_ready(q_ready), .out_data(w_data),
        .out_index(w_index), .mem_we(w_we), .mem_addr(w_addr), .mem_wdata(w_wdata),
        .busy(w_busy), .done(w_done), .overflow(w_ovf), .term_count(w_tc));

    fib_stream_gen #(.ADDR_W(4)) dut_r (
        .clk(clk), .rst(rst), .start(q_start), .n_terms(r_n), .seed0(r_s0), .seed1(r_s1),
        .base_addr(r_base), .out_valid(r_valid), .out_ready(q_ready), .out_data(r_data),
        .out_index(r_index), .mem_we(r_we), .mem_addr(r_addr), .mem_wdata(r_wdata),
        .busy(r_busy), .done(r_done), .overflow(r_ovf), .term_count(r_tc));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, " valid"}, a_valid, 0);
        chk({tag, " data"}, a_data, 0);
        chk({tag, " index"}, a_index, 0);
        chk({tag, " we"}, a_we, 0);
        chk({tag, " addr"}, a_addr, 0);
        chk({tag, " wdata"}, a_wdata, 0);
        chk({tag, " busy"}, a_busy, 0);
        chk({tag, " done"}, a_done, 0);
        chk({tag, " ovf"}, a_ovf, 0);
        chk({tag, " tc"}, a_tc, 0);
    endtask

    // One run on the 32-bit instance. bp toggles out_ready 1,0,0,1; poke pulses
    // start (with a different seed) mid-run; abort_at asserts rst after that many handshakes.
    task automatic run_a(input string nm, input int n, input logic [31:0] s0, input logic [31:0] s1,
                         input logic [8:0] base, input bit bp, input bit poke, input int abort_at);
        logic [31:0] ea, eb, tmp, held_d, last_d;
        logic [15:0] held_i;
        logic [8:0]  ex_addr;
        bit          held;
        int          k, last_hs, done_cnt, done_cyc, we_cnt;
        ea = s0; eb = s1; k = 0; last_hs = -1; done_cnt = 0; done_cyc = -9; we_cnt = 0;
        held = 1'b0; held_d = '0; held_i = '0; last_d = '0;
        @(negedge clk);
        a_start = 1'b1; a_n = 16'(n); a_s0 = s0; a_s1 = s1; a_base = base; a_ready = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            a_start = poke && (k == 2);
            if (poke && k == 2) a_s0 = 32'd99;
            a_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            #1;
            if (a_done) begin done_cnt++; done_cyc = cyc; end
            if (held) begin
                chk({nm, " held data"}, a_data, held_d);
                chk({nm, " held index"}, a_index, held_i);
            end
            held = a_valid && !a_ready; held_d = a_data; held_i = a_index;
            if (a_valid) begin
                chk({nm, " data"}, a_data, ea);
                chk({nm, " index"}, a_index, k);
                chk({nm, " busy"}, a_busy, 1);
            end
            chk({nm, " we"}, a_we, a_valid && a_ready);
            if (a_valid && a_ready) begin
                ex_addr = base + 9'(k);
                chk({nm, " addr"}, a_addr, ex_addr);
                chk({nm, " wdata"}, a_wdata, ea);
                we_cnt++; last_hs = cyc; last_d = ea; k++;
                tmp = ea + eb; ea = eb; eb = tmp;
                if (k == abort_at) begin
                    @(posedge clk);
                    #2 rst = 1'b1;
                    #1 chk_a_zero({nm, " async rst"});
                    repeat (3) begin
                        @(negedge clk);
                        chk({nm, " rst we"}, a_we, 0);
                    end
                    rst = 1'b0;
                    return;
                end
            end
            if (done_cnt > 0 && cyc > done_cyc + 2) break;
        end
        chk({nm, " terms"}, k, n);
        chk({nm, " we count"}, we_cnt, n);
        chk({nm, " done count"}, done_cnt, 1);
        chk({nm, " done timing"}, done_cyc, last_hs + 1);
        chk({nm, " term_count"}, a_tc, n);
        chk({nm, " overflow"}, a_ovf, 0);
        if (n == 10 && s0 == 0 && s1 == 1) chk({nm, " last term"}, last_d, 34);
        if (n == 3 && s0 == 2 && s1 == 3) chk({nm, " last term"}, last_d, 5);
    endtask

    logic [7:0]  sa, sb, st, wa, wb, wt, s_last;
    logic [3:0]  r_exp [4];
    int          sk, wk, rk, s_dc, w_dc, r_dc, s_dcyc, s_lhs;

    initial begin
        rst = 1'b1;
        a_start = 0; a_ready = 0; a_n = 0; a_s0 = 0; a_s1 = 0; a_base = 0;
        q_start = 0; q_ready = 0; q_s0 = 0; q_s1 = 0; q_base = 0; s_n = 0; w_n = 0;
        r_n = 0; r_s0 = 0; r_s1 = 0; r_base = 0;
        #12;
        chk_a_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        run_a("basic", 10, 32'd0, 32'd1, 9'd4, 1'b0, 1'b0, 0);
        run_a("backpressure", 10, 32'd0, 32'd1, 9'd4, 1'b1, 1'b0, 0);
        run_a("n0", 0, 32'd0, 32'd1, 9'd4, 1'b0, 1'b0, 0);
        run_a("poke", 6, 32'd0, 32'd1, 9'd4, 1'b0, 1'b1, 0);
        run_a("abort", 10, 32'd0, 32'd1, 9'd4, 1'b0, 1'b0, 3);
        run_a("after rst", 3, 32'd2, 32'd3, 9'd0, 1'b0, 1'b0, 0);

        // 8-bit stop/wrap and 4-bit address wrap, run side by side
        r_exp[0] = 4'd14; r_exp[1] = 4'd15; r_exp[2] = 4'd0; r_exp[3] = 4'd1;
        sa = 0; sb = 1; wa = 0; wb = 1; sk = 0; wk = 0; rk = 0;
        s_dc = 0; w_dc = 0; r_dc = 0; s_dcyc = -9; s_lhs = -1; s_last = 0;
        @(negedge clk);
        q_start = 1; q_ready = 1; q_s0 = 0; q_s1 = 1; q_base = 0;
        s_n = 16'd20; w_n = 16'd16; r_n = 16'd4; r_s0 = 0; r_s1 = 1; r_base = 4'd14;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            q_start = 0;
            #1;
            if (s_done) begin s_dc++; s_dcyc = cyc; end
            if (w_done) w_dc++;
            if (r_done) r_dc++;
            if (s_valid) begin
                chk("stop data", s_data, sa);
                chk("stop index", s_index, sk);
                chk("stop we", s_we, 1);
                s_last = sa; s_lhs = cyc; sk++;
                st = sa + sb; sa = sb; sb = st;
            end
            if (w_valid) begin
                chk("wrap data", w_data, wa);
                chk("wrap index", w_index, wk);
                if (wk == 14) chk("wrap idx14", w_data, 121);
                if (wk == 15) chk("wrap idx15", w_data, 98);
                wk++;
                wt = wa + wb; wa = wb; wb = wt;
            end
            if (r_we) begin
                if (rk < 4) chk("addr wrap", r_addr, r_exp[rk]);
                rk++;
            end
        end
        chk("stop terms", sk, 14);
        chk("stop last", s_last, 233);
        chk("stop term_count", s_tc, 14);
        chk("stop overflow", s_ovf, 1);
        chk("stop done count", s_dc, 1);
        chk("stop done timing", s_dcyc, s_lhs + 1);
        chk("wrap terms", wk, 16);
        chk("wrap term_count", w_tc, 16);
        chk("wrap overflow", w_ovf, 1);
        chk("wrap done count", w_dc, 1);
        chk("addr wrap writes", rk, 4);
        chk("addr wrap done count", r_dc, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
